// File: rtl/uart_fifo.sv
// Single-clock byte FIFO between a UART and host logic.
// Registered read data; full/empty decoded from the registered occupancy count.
module uart_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic                  rd,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wptr_q, wptr_d;
    logic [AW-1:0]         rptr_q, rptr_d;
    logic [AW:0]           cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  wr_ok, rd_ok;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == FULL_CNT);

    // A read frees a slot this cycle, so a write into a full FIFO can still land.
    assign rd_ok = rd & ~empty;
    assign wr_ok = wr & (~full | rd_ok);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        dout_d = dout_q;
        if (wr_ok) wptr_d = wptr_q + 1'b1;
        if (rd_ok) begin
            rptr_d = rptr_q + 1'b1;
            dout_d = mem_q[rptr_q];
        end
        case ({wr_ok, rd_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            dout_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
        end
    end

    // Storage is not reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (rst && wr_ok) mem_q[wptr_q] <= data_in;
    end

    assign data_out = dout_q;
endmodule

// File: tb/tb_uart_fifo.sv
// Scenario bench for uart_fifo: a queue scoreboard predicts data_out and the flags.
module tb_uart_fifo;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr = 1'b0, rd = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       empty, full;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] exp_q [$];
    logic [7:0] exp_dout = 8'h00;

    uart_fifo #(.DATA_WIDTH(8), .DEPTH(8)) dut (
        .clk(clk), .rst(rst), .wr(wr), .rd(rd),
        .data_in(data_in), .data_out(data_out), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    // One cycle of stimulus; scoreboard pops on accepted read, pushes on accepted write.
    task automatic drive(input logic w, input logic r, input logic [7:0] d);
        logic r_ok, w_ok;
        r_ok = r && (exp_q.size() > 0);
        w_ok = w && ((exp_q.size() < 8) || r_ok);
        wr = w; rd = r; data_in = d;
        @(posedge clk);
        if (r_ok) exp_dout = exp_q.pop_front();
        if (w_ok) exp_q.push_back(d);
        #1;
        wr = 1'b0; rd = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; wr = 1'b1; rd = 1'b1; data_in = 8'h77;
        @(posedge clk); #1;
        rst = 1'b1; wr = 1'b0; rd = 1'b0;
        exp_q.delete(); exp_dout = 8'h00;
        vectors++;
        if (data_out !== 8'h00 || empty !== 1'b1 || full !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: dout=%h empty=%b full=%b, expected dout=00 empty=1 full=0",
                     data_out, empty, full);
        end
    endtask

    task automatic test_underflow();
        drive(1'b0, 1'b1, 8'h00);
        vectors++;
        if (data_out !== 8'h00 || empty !== 1'b1) begin
            miscompares++;
            $display("FAIL underflow: dout=%h empty=%b, expected dout=00 empty=1", data_out, empty);
        end
        drive(1'b1, 1'b0, 8'h3C);
        vectors++;
        if (empty !== 1'b0) begin
            miscompares++;
            $display("FAIL underflow_wr: empty=%b expected 0", empty);
        end
        drive(1'b0, 1'b1, 8'h00);
        vectors++;
        if (data_out !== exp_dout || empty !== 1'b1) begin
            miscompares++;
            $display("FAIL underflow_rd: dout=%h empty=%b, expected dout=%h empty=1",
                     data_out, empty, exp_dout);
        end
    endtask

    task automatic test_fill(input logic [7:0] base);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, base + 8'(i));
            vectors++;
            if (empty !== 1'b0 || full !== (exp_q.size() == 8)) begin
                miscompares++;
                $display("FAIL fill[%0d]: empty=%b full=%b, expected empty=0 full=%b",
                         i, empty, full, exp_q.size() == 8);
            end
        end
    endtask

    task automatic test_overflow();
        drive(1'b1, 1'b0, 8'hFF);
        vectors++;
        if (full !== 1'b1 || exp_q.size() != 8) begin
            miscompares++;
            $display("FAIL overflow: full=%b model_cnt=%0d, expected full=1 cnt=8",
                     full, exp_q.size());
        end
    endtask

    task automatic test_drain(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b1, 8'h00);
            vectors++;
            if (data_out !== exp_dout || data_out === 8'hFF || full !== 1'b0 ||
                empty !== (exp_q.size() == 0)) begin
                miscompares++;
                $display("FAIL drain[%0d]: dout=%h empty=%b full=%b, expected dout=%h empty=%b full=0",
                         i, data_out, empty, full, exp_dout, exp_q.size() == 0);
            end
        end
    endtask

    task automatic test_simul_wrap();
        test_fill(8'h01);
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 1'b1, 8'h10 + 8'(i));
            vectors++;
            if (data_out !== exp_dout || full !== 1'b1) begin
                miscompares++;
                $display("FAIL simul[%0d]: dout=%h full=%b, expected dout=%h full=1",
                         i, data_out, full, exp_dout);
            end
        end
        test_drain(8);
    endtask

    task automatic test_empty_simul();
        logic [7:0] prev;
        prev = data_out;
        drive(1'b1, 1'b1, 8'h55);
        vectors++;
        if (data_out !== exp_dout || data_out !== prev || empty !== 1'b0) begin
            miscompares++;
            $display("FAIL empty_simul: dout=%h empty=%b, expected dout=%h empty=0",
                     data_out, empty, exp_dout);
        end
        drive(1'b0, 1'b1, 8'h00);
        vectors++;
        if (data_out !== 8'h55 || empty !== 1'b1) begin
            miscompares++;
            $display("FAIL empty_simul_rd: dout=%h empty=%b, expected dout=55 empty=1",
                     data_out, empty);
        end
    endtask

    task automatic test_mid_reset();
        drive(1'b1, 1'b0, 8'hC1);
        drive(1'b1, 1'b0, 8'hC2);
        test_reset();
        drive(1'b0, 1'b1, 8'h00);
        vectors++;
        if (data_out !== 8'h00 || empty !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_reset: dout=%h empty=%b, expected dout=00 empty=1", data_out, empty);
        end
    endtask

    initial begin
        test_reset();
        test_underflow();
        test_fill(8'hA1);
        test_overflow();
        test_drain(8);
        test_drain(1);
        vectors++;
        if (data_out !== 8'hA8) begin
            miscompares++;
            $display("FAIL ninth_read: dout=%h expected a8", data_out);
        end
        test_simul_wrap();
        test_empty_simul();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
